// File: rtl/dsp_slice_pkg.sv
// Shared constants for the MAC slice: OPMODE bit positions and X/Z mux encodings.
package dsp_slice_pkg;

  localparam int unsigned OpmodeW   = 8;
  localparam int unsigned SelW      = 2;
  localparam int unsigned OpXLsb    = 0;
  localparam int unsigned OpZLsb    = 2;
  localparam int unsigned OpPreEn   = 4;
  localparam int unsigned OpCinEn   = 5;
  localparam int unsigned OpPreSub  = 6;
  localparam int unsigned OpPostSub = 7;

  typedef enum logic [SelW-1:0] {
    XZero = 2'd0,
    XM    = 2'd1,
    XP    = 2'd2,
    XDab  = 2'd3
  } x_sel_e;

  typedef enum logic [SelW-1:0] {
    ZZero = 2'd0,
    ZPcin = 2'd1,
    ZP    = 2'd2,
    ZC    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Clock-enabled delay line of DEPTH stages with synchronous active-high clear.
// DEPTH = 0 is a plain wire.
module dsp_pipe_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, ce_i};
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= '0;
        end
      end else if (ce_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_slice.sv
// DSP MAC slice: pre-adder, unsigned multiplier, X/Z muxed post-adder with optional
// saturation and pattern detect. Latency IREG+MREG+PREG enabled cycles.
module dsp_mac_slice
  import dsp_slice_pkg::*;
#(
  parameter int unsigned     A_W     = 18,
  parameter int unsigned     B_W     = 18,
  parameter int unsigned     P_W     = 48,
  parameter int unsigned     IREG    = 1,
  parameter int unsigned     MREG    = 1,
  parameter int unsigned     PREG    = 1,
  parameter int unsigned     SAT_EN  = 0,
  parameter logic [P_W-1:0]  PATTERN = '0,
  parameter logic [P_W-1:0]  MASK    = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  input  logic [B_W-1:0]     D,
  input  logic [P_W-1:0]     C,
  input  logic [P_W-1:0]     PCIN,
  input  logic               CARRYIN,
  input  logic [7:0]         OPMODE,
  output logic [B_W-1:0]     BCOUT,
  output logic [A_W+B_W-1:0] M,
  output logic [P_W-1:0]     P,
  output logic [P_W-1:0]     PCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF,
  output logic               PATDET,
  output logic               OVERFLOW,
  output logic               OUT_VALID
);

  localparam int unsigned M_W   = A_W + B_W;
  localparam int unsigned DAB_W = A_W + 2 * B_W;
  localparam int unsigned SUM_W = P_W + 1;
  localparam int unsigned CTL_W = 2 + 2 * SelW;
  localparam int unsigned IN_W  = 2 + OpmodeW + 2 * P_W + 2 * B_W + A_W;
  localparam int unsigned MID_W = 1 + CTL_W + 2 * P_W + DAB_W + M_W;
  localparam int unsigned OUT_W = 4 + P_W;

  // Input stage
  logic [IN_W-1:0]    in_d, in_q;
  logic               valid_r, carryin_r;
  logic [OpmodeW-1:0] opmode_r;
  logic [P_W-1:0]     pcin_r, c_r;
  logic [B_W-1:0]     d_r, b_r;
  logic [A_W-1:0]     a_r;

  assign in_d = {IN_VALID, CARRYIN, OPMODE, PCIN, C, D, B, A};

  dsp_pipe_reg #(
    .WIDTH(IN_W),
    .DEPTH(IREG)
  ) u_in_pipe (
    .clk_i(CLK),
    .rst_i(RST),
    .ce_i (CE),
    .d_i  (in_d),
    .q_o  (in_q)
  );

  assign {valid_r, carryin_r, opmode_r, pcin_r, c_r, d_r, b_r, a_r} = in_q;

  // Pre-adder and multiplier
  logic [B_W-1:0]   bcout;
  logic [M_W-1:0]   m_prod;
  logic [CTL_W-1:0] post_ctl;

  always_comb begin
    bcout = b_r;
    if (opmode_r[OpPreEn]) begin
      bcout = opmode_r[OpPreSub] ? (d_r - b_r) : (d_r + b_r);
    end
  end

  assign m_prod = M_W'(a_r) * M_W'(bcout);

  // Only the post-adder controls travel on; carry-in is gated here once.
  assign post_ctl = {opmode_r[OpPostSub], carryin_r & opmode_r[OpCinEn],
                     opmode_r[OpZLsb +: SelW], opmode_r[OpXLsb +: SelW]};

  // Multiplier stage, with the post-adder operands aligned to M
  logic [MID_W-1:0] mid_d, mid_q;
  logic             valid_m, post_sub_m, cin_m;
  logic [SelW-1:0]  z_sel_m, x_sel_m;
  logic [P_W-1:0]   pcin_m, c_m;
  logic [DAB_W-1:0] dab_m;
  logic [M_W-1:0]   m_m;

  assign mid_d = {valid_r, post_ctl, pcin_r, c_r, d_r, a_r, b_r, m_prod};

  dsp_pipe_reg #(
    .WIDTH(MID_W),
    .DEPTH(MREG)
  ) u_mid_pipe (
    .clk_i(CLK),
    .rst_i(RST),
    .ce_i (CE),
    .d_i  (mid_d),
    .q_o  (mid_q)
  );

  assign {valid_m, post_sub_m, cin_m, z_sel_m, x_sel_m, pcin_m, c_m, dab_m, m_m} = mid_q;

  // Post-adder
  logic [P_W-1:0]   p_fb;
  logic [P_W-1:0]   x_val, z_val, p_fin;
  logic [SUM_W-1:0] x_ext, sum;
  logic             carry, ovf, patdet;
  logic [OUT_W-1:0] out_d, out_q;
  logic [P_W-1:0]   p_out;

  // Without an output register the P feedback would be a combinational loop.
  if (PREG != 0) begin : g_fb
    assign p_fb = p_out;
  end else begin : g_no_fb
    assign p_fb = '0;
  end

  always_comb begin
    x_val = '0;
    unique case (x_sel_m)
      XZero:   x_val = '0;
      XM:      x_val = P_W'(m_m);
      XP:      x_val = p_fb;
      XDab:    x_val = P_W'(dab_m);
      default: x_val = '0;
    endcase
  end

  always_comb begin
    z_val = '0;
    unique case (z_sel_m)
      ZZero:   z_val = '0;
      ZPcin:   z_val = pcin_m;
      ZP:      z_val = p_fb;
      ZC:      z_val = c_m;
      default: z_val = '0;
    endcase
  end

  always_comb begin
    x_ext = {1'b0, x_val} + SUM_W'(cin_m);
    if (post_sub_m) begin
      sum = {1'b0, z_val} - x_ext;
    end else begin
      sum = {1'b0, z_val} + x_ext;
    end
    carry = sum[P_W];
    ovf   = carry;
    p_fin = sum[P_W-1:0];
    if ((SAT_EN != 0) && carry) begin
      p_fin = post_sub_m ? '0 : '1;
    end
    patdet = (((p_fin ^ PATTERN) & ~MASK) == '0);
  end

  // Output stage
  assign out_d = {valid_m, patdet, ovf, carry, p_fin};

  dsp_pipe_reg #(
    .WIDTH(OUT_W),
    .DEPTH(PREG)
  ) u_out_pipe (
    .clk_i(CLK),
    .rst_i(RST),
    .ce_i (CE),
    .d_i  (out_d),
    .q_o  (out_q)
  );

  assign {OUT_VALID, PATDET, OVERFLOW, CARRYOUT, p_out} = out_q;

  assign CARRYOUTF = CARRYOUT;
  assign P         = p_out;
  assign PCOUT     = p_out;
  assign M         = m_m;
  assign BCOUT     = bcout;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: a default-parameter instance (PATTERN=700) and a
// saturating instance share the same stimulus.
module tb_dsp_mac_slice;

  logic        CLK = 1'b0;
  logic        RST, CE, IN_VALID, CARRYIN;
  logic [17:0] A, B, D;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;

  logic [17:0] bcout, s_bcout;
  logic [35:0] m, s_m;
  logic [47:0] p, pcout, s_p, s_pcout;
  logic        co, cof, patdet, ovf, ov;
  logic        s_co, s_cof, s_patdet, s_ovf, s_ov;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dsp_mac_slice #(
    .PATTERN(48'd700)
  ) u_dut (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(bcout), .M(m), .P(p), .PCOUT(pcout), .CARRYOUT(co), .CARRYOUTF(cof),
    .PATDET(patdet), .OVERFLOW(ovf), .OUT_VALID(ov)
  );

  dsp_mac_slice #(
    .SAT_EN(1)
  ) u_sat (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(s_bcout), .M(s_m), .P(s_p), .PCOUT(s_pcout), .CARRYOUT(s_co), .CARRYOUTF(s_cof),
    .PATDET(s_patdet), .OVERFLOW(s_ovf), .OUT_VALID(s_ov)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_inputs();
    CE = 1'b1; IN_VALID = 1'b0; CARRYIN = 1'b0;
    A = '0; B = '0; D = '0; C = '0; PCIN = '0; OPMODE = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'($urandom); IN_VALID = 1'b1; CARRYIN = 1'($urandom);
    A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
    C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
    OPMODE = 8'($urandom);
    tick();
    tick();
    vectors++;
    if ({p, pcout, m, bcout} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got p=%0h pcout=%0h m=%0h bcout=%0h want 0", p, pcout, m, bcout);
    end
    vectors++;
    if ({co, cof, patdet, ovf, ov} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {co, cof, patdet, ovf, ov});
    end
    vectors++;
    if ({s_p, s_m, s_bcout, s_co, s_ovf, s_ov} !== '0) begin
      miscompares++;
      $display("FAIL reset_sat: got p=%0h ovf=%b ov=%b want 0", s_p, s_ovf, s_ov);
    end
    RST = 1'b0;
    zero_inputs();
  endtask

  task automatic test_reset_flush();
    do_reset();
    A = 18'd20; B = 18'd10; D = 18'd25; OPMODE = 8'b00010001; IN_VALID = 1'b1;
    tick();
    zero_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ov !== 1'b0 || p !== 48'd0) begin
        miscompares++;
        $display("FAIL flush_%0d: got ov=%b p=%0d want ov=0 p=0", i, ov, p);
      end
    end
  endtask

  task automatic test_mult_patdet();
    do_reset();
    A = 18'd20; B = 18'd10; D = 18'd25; OPMODE = 8'b00010001; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    vectors++;
    if (bcout !== 18'd35) begin
      miscompares++;
      $display("FAIL mult_bcout: got %0d want 35", bcout);
    end
    tick();
    vectors++;
    if (m !== 36'h2BC || p !== 48'd0 || ov !== 1'b0 || patdet !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_c2: got m=%0h p=%0h ov=%b patdet=%b want m=2bc p=0 ov=0 patdet=0",
               m, p, ov, patdet);
    end
    tick();
    vectors++;
    if (p !== 48'h2BC || pcout !== 48'h2BC || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL mult_c3: got p=%0h pcout=%0h ov=%b want p=2bc pcout=2bc ov=1", p, pcout, ov);
    end
    vectors++;
    if (patdet !== 1'b1 || s_patdet !== 1'b0) begin
      miscompares++;
      $display("FAIL patdet_hit: got %b/%b want 1/0", patdet, s_patdet);
    end
    tick();
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_pulse_once: got ov=%b want 0", ov);
    end
  endtask

  task automatic test_accumulate();
    logic [47:0] exp_p [4] = '{48'd12, 48'd24, 48'd36, 48'd48};
    do_reset();
    A = 18'd3; B = 18'd4; OPMODE = 8'b00001001; IN_VALID = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) IN_VALID = 1'b0;
      tick();
      vectors++;
      if (p !== exp_p[i] || ov !== 1'b1) begin
        miscompares++;
        $display("FAIL accum_%0d: got p=%0d ov=%b want p=%0d ov=1", i, p, ov, exp_p[i]);
      end
    end
    tick();
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++;
      $display("FAIL accum_end: got ov=%b want 0", ov);
    end
  endtask

  task automatic test_stall();
    do_reset();
    A = 18'd3; B = 18'd4; OPMODE = 8'b00001001; IN_VALID = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (p !== 48'd12 || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_pre: got p=%0d ov=%b want p=12 ov=1", p, ov);
    end
    CE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (p !== 48'd12 || ov !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got p=%0d ov=%b want p=12 ov=1", i, p, ov);
      end
    end
    CE = 1'b1;
    tick();
    IN_VALID = 1'b0;
    vectors++;
    if (p !== 48'd24 || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_resume: got p=%0d ov=%b want p=24 ov=1", p, ov);
    end
    tick();
    tick();
    vectors++;
    if (p !== 48'd48 || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_last: got p=%0d ov=%b want p=48 ov=1", p, ov);
    end
    tick();
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: got ov=%b want 0", ov);
    end
  endtask

  task automatic test_sub_sat();
    do_reset();
    A = 18'd5; B = 18'd6; C = 48'd350; OPMODE = 8'b10001101; IN_VALID = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (p !== 48'd320 || co !== 1'b0 || ovf !== 1'b0 || s_p !== 48'd320) begin
      miscompares++;
      $display("FAIL sub_pos: got p=%0d co=%b ovf=%b sat_p=%0d want 320/0/0/320",
               p, co, ovf, s_p);
    end
    C = 48'd10;
    tick(); tick(); tick();
    vectors++;
    if (p !== 48'hFFFF_FFFF_FFEC || co !== 1'b1 || cof !== 1'b1 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_wrap: got p=%0h co=%b cof=%b ovf=%b want ffffffffffec/1/1/1",
               p, co, cof, ovf);
    end
    vectors++;
    if (s_p !== 48'd0 || s_ovf !== 1'b1 || s_co !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_sat: got p=%0h ovf=%b co=%b want 0/1/1", s_p, s_ovf, s_co);
    end
    C = 48'hFFFF_FFFF_FFF0; OPMODE = 8'b00001101;
    tick(); tick(); tick();
    vectors++;
    if (p !== 48'd14 || co !== 1'b1 || s_p !== 48'hFFFF_FFFF_FFFF || s_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL add_sat: got p=%0h co=%b sat_p=%0h sat_ovf=%b want e/1/ffffffffffff/1",
               p, co, s_p, s_ovf);
    end
  endtask

  task automatic test_preadd_cin();
    logic [47:0] exp_dab;
    do_reset();
    A = 18'd2; B = 18'd10; D = 18'd25; PCIN = 48'd100; CARRYIN = 1'b1;
    OPMODE = 8'b01110101;
    tick();
    vectors++;
    if (bcout !== 18'd15) begin
      miscompares++;
      $display("FAIL pre_sub: got %0d want 15", bcout);
    end
    tick(); tick();
    vectors++;
    if (p !== 48'd131 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL pcin_cin: got p=%0d co=%b want 131/0", p, co);
    end
    D = 18'd5;
    tick();
    vectors++;
    if (bcout !== 18'd262139) begin
      miscompares++;
      $display("FAIL pre_wrap: got %0d want 262139", bcout);
    end
    A = 18'd1; B = 18'd2; D = 18'd3; CARRYIN = 1'b0; OPMODE = 8'b00000011;
    exp_dab = (48'd3 << 36) | (48'd1 << 18) | 48'd2;
    tick(); tick(); tick();
    vectors++;
    if (p !== exp_dab) begin
      miscompares++;
      $display("FAIL x_dab: got %0h want %0h", p, exp_dab);
    end
  endtask

  initial begin
    RST = 1'b1;
    zero_inputs();
    test_reset();
    test_reset_flush();
    test_mult_patdet();
    test_accumulate();
    test_stall();
    test_sub_sat();
    test_preadd_cin();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
